spi_reg_target: RTL and testbench

Oversampled 3-wire SPI register target: the responder side of the llspi initiator protocol used toward the AD9653 ADCs, with the same instruction and data framing. It decodes 16-bit instructions, services single-byte, multi-byte and streaming reads and writes against an internal 8-bit register file, and turns SDIO around for reads. It sits in FPGA fabric as a chip emulator for loopback and bench work, and as a configuration port for in-fabric peripherals. All logic runs on one system clock; SCLK is sampled, not used as a clock.

---
 rtl/spi_target_pkg.sv | 21 ++
 rtl/spi_target_regfile.sv | 43 ++++
 rtl/spi_reg_target.sv | 232 +++++++++++++++++++++++
 tb/tb_spi_reg_target.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_target_pkg.sv
// spi_target_pkg: shared state type and instruction layout
// for the oversampled 3-wire SPI register target.
package spi_target_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_INSTR = 2'd1,
    S_WDATA = 2'd2,
    S_RDATA = 2'd3
  } state_e;

  localparam int INSTR_BITS = 16;
  localparam int BYTE_BITS  = 8;

  localparam int RW_POS = 15;
  localparam int W_HI   = 14;
  localparam int W_LO   = 13;

  localparam logic [1:0] W_STREAM = 2'b11;

endpackage

// File: rtl/spi_target_regfile.sv
// spi_target_regfile: 2^AW x 8 register file, one write port,
// registered SPI and local read ports, cleared by reset.
module spi_target_regfile #(
  parameter int AW = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] spi_addr_i,
  output logic [7:0]    spi_data_o,
  input  logic [AW-1:0] loc_addr_i,
  output logic [7:0]    loc_data_o
);

  localparam int DEPTH = 1 << AW;

  logic [7:0] mem_q [DEPTH];
  logic [7:0] spi_q;
  logic [7:0] loc_q;

  // Reads sample the array before this edge's write lands.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      spi_q <= '0;
      loc_q <= '0;
    end else begin
      if (we_i) begin
        mem_q[waddr_i] <= wdata_i;
      end
      spi_q <= mem_q[spi_addr_i];
      loc_q <= mem_q[loc_addr_i];
    end
  end

  assign spi_data_o = spi_q;
  assign loc_data_o = loc_q;

endmodule

// File: rtl/spi_reg_target.sv
// spi_reg_target: oversampled 3-wire SPI register target,
// 16-bit instruction, descending multi-byte/streaming access.
module spi_reg_target
  import spi_target_pkg::*;
#(
  parameter int aw     = 8,
  parameter int sync_n = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sclk,
  input  logic          csb,
  input  logic          sdio_in,
  output logic          sdio_out,
  output logic          sdio_oe,
  input  logic [aw-1:0] loc_addr,
  output logic [7:0]    loc_data,
  output logic          wr_stb,
  output logic [aw-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          frame_err,
  output logic          busy
);

  localparam logic [3:0] LAST_INSTR = 4'(INSTR_BITS - 1);
  localparam logic [3:0] LAST_BIT   = 4'(BYTE_BITS - 1);
  localparam logic [aw-1:0] A_ONE   = aw'(1);

  logic [sync_n-1:0] sclk_q, csb_q, sdio_q;
  logic sclk_prev_q, csb_prev_q;
  logic sclk_s, csb_s, sdio_s;
  logic rise, fall, csb_fall, csb_rise;

  state_e state_q, state_d;
  logic [3:0] bitcnt_q, bitcnt_d;
  logic [14:0] isr_q, isr_d;
  logic [7:0] dsr_q, dsr_d;
  logic [aw-1:0] addr_q, addr_d;
  logic [1:0] left_q, left_d;
  logic stream_q, stream_d;
  logic done_q, done_d;
  logic ld_q, ld_d;
  logic oe_q, oe_d;
  logic sdo_q, sdo_d;
  logic stb_q, stb_d;
  logic [aw-1:0] waddr_q, waddr_d;
  logic [7:0] wdata_q, wdata_d;
  logic ferr_q, ferr_d;
  logic byte_end;
  logic [7:0] rf_spi;

  assign sclk_s = sclk_q[sync_n-1];
  assign csb_s  = csb_q[sync_n-1];
  assign sdio_s = sdio_q[sync_n-1];

  assign rise     = sclk_s & ~sclk_prev_q;
  assign fall     = ~sclk_s & sclk_prev_q;
  assign csb_fall = ~csb_s & csb_prev_q;
  assign csb_rise = csb_s & ~csb_prev_q;

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    isr_d    = isr_q;
    dsr_d    = dsr_q;
    addr_d   = addr_q;
    left_d   = left_q;
    stream_d = stream_q;
    done_d   = done_q;
    ld_d     = 1'b0;
    oe_d     = oe_q;
    sdo_d    = sdo_q;
    stb_d    = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    ferr_d   = ferr_q;
    byte_end = 1'b0;

    if (csb_rise) begin
      state_d  = S_IDLE;
      oe_d     = 1'b0;
      bitcnt_d = '0;
      done_d   = 1'b0;
      if (bitcnt_q != '0 || state_q == S_INSTR) begin
        ferr_d = 1'b1;
      end
    end else begin
      if (ld_q) begin
        dsr_d = rf_spi;
      end
      unique case (state_q)
        S_IDLE: begin
          if (csb_fall) begin
            state_d  = S_INSTR;
            bitcnt_d = '0;
          end
        end
        S_INSTR: begin
          if (rise) begin
            isr_d    = {isr_q[13:0], sdio_s};
            bitcnt_d = bitcnt_q + 4'd1;
            if (bitcnt_q == LAST_INSTR) begin
              addr_d   = {isr_q[aw-2:0], sdio_s};
              left_d   = isr_q[W_HI-1:W_LO-1];
              stream_d = isr_q[W_HI-1:W_LO-1] == W_STREAM;
              done_d   = 1'b0;
              if (isr_q[RW_POS-1]) begin
                state_d = S_RDATA;
                ld_d    = 1'b1;
              end else begin
                state_d = S_WDATA;
              end
            end
          end
        end
        S_WDATA: begin
          if (rise && !done_q) begin
            dsr_d    = {dsr_q[6:0], sdio_s};
            bitcnt_d = bitcnt_q + 4'd1;
            if (bitcnt_q == LAST_BIT) begin
              bitcnt_d = '0;
              stb_d    = 1'b1;
              waddr_d  = addr_q;
              wdata_d  = {dsr_q[6:0], sdio_s};
              addr_d   = addr_q - A_ONE;
              byte_end = 1'b1;
            end
          end
        end
        S_RDATA: begin
          // Drive on falls, count on rises: the initiator
          // samples each bit on the rise that follows.
          if (fall) begin
            if (done_q) begin
              oe_d = 1'b0;
            end else begin
              oe_d  = 1'b1;
              sdo_d = dsr_q[7];
              dsr_d = {dsr_q[6:0], 1'b0};
            end
          end else if (rise && !done_q) begin
            bitcnt_d = bitcnt_q + 4'd1;
            if (bitcnt_q == LAST_BIT) begin
              bitcnt_d = '0;
              addr_d   = addr_q - A_ONE;
              ld_d     = 1'b1;
              byte_end = 1'b1;
            end
          end
        end
      endcase
      if (byte_end && !stream_q) begin
        if (left_q == 2'd0) begin
          done_d = 1'b1;
        end else begin
          left_d = left_q - 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_q      <= '0;
      csb_q       <= '0;
      sdio_q      <= '0;
      sclk_prev_q <= 1'b0;
      csb_prev_q  <= 1'b0;
      state_q     <= S_IDLE;
      bitcnt_q    <= '0;
      isr_q       <= '0;
      dsr_q       <= '0;
      addr_q      <= '0;
      left_q      <= '0;
      stream_q    <= 1'b0;
      done_q      <= 1'b0;
      ld_q        <= 1'b0;
      oe_q        <= 1'b0;
      sdo_q       <= 1'b0;
      stb_q       <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      ferr_q      <= 1'b0;
    end else begin
      sclk_q      <= (sclk_q << 1) | sync_n'(sclk);
      csb_q       <= (csb_q << 1) | sync_n'(csb);
      sdio_q      <= (sdio_q << 1) | sync_n'(sdio_in);
      sclk_prev_q <= sclk_s;
      csb_prev_q  <= csb_s;
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      isr_q       <= isr_d;
      dsr_q       <= dsr_d;
      addr_q      <= addr_d;
      left_q      <= left_d;
      stream_q    <= stream_d;
      done_q      <= done_d;
      ld_q        <= ld_d;
      oe_q        <= oe_d;
      sdo_q       <= sdo_d;
      stb_q       <= stb_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      ferr_q      <= ferr_d;
    end
  end

  // SPI port is addressed with the next address so a
  // reload is ready one clock after it is requested.
  spi_target_regfile #(
    .AW(aw)
  ) u_rf (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .we_i       (stb_q),
    .waddr_i    (waddr_q),
    .wdata_i    (wdata_q),
    .spi_addr_i (addr_d),
    .spi_data_o (rf_spi),
    .loc_addr_i (loc_addr),
    .loc_data_o (loc_data)
  );

  assign sdio_out  = sdo_q;
  assign sdio_oe   = oe_q;
  assign wr_stb    = stb_q;
  assign wr_addr   = waddr_q;
  assign wr_data   = wdata_q;
  assign frame_err = ferr_q;
  assign busy      = state_q != S_IDLE;

endmodule

// File: tb/tb_spi_reg_target.sv
// tb_spi_reg_target: table-driven SPI transactions with
// write/read scoreboards plus framing and reset sequences.
module tb_spi_reg_target;

  localparam int HALF = 40;

  logic clk;
  logic rst_n;
  logic sclk;
  logic csb;
  logic sdio_in;
  logic sdio_out;
  logic sdio_oe;
  logic [7:0] loc_addr;
  logic [7:0] loc_data;
  logic wr_stb;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic frame_err;
  logic busy;

  spi_reg_target #(
    .aw(8),
    .sync_n(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sclk      (sclk),
    .csb       (csb),
    .sdio_in   (sdio_in),
    .sdio_out  (sdio_out),
    .sdio_oe   (sdio_oe),
    .loc_addr  (loc_addr),
    .loc_data  (loc_data),
    .wr_stb    (wr_stb),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .frame_err (frame_err),
    .busy      (busy)
  );

  typedef struct packed {
    logic            rw;
    logic [1:0]      w;
    logic [7:0]      addr;
    logic [1:0]      nb;
    logic [0:2][7:0] d;
  } vec_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t exp_wq[$];
  logic [7:0] exp_rq[$];

  int n_tests = 0;
  int n_fail = 0;
  int stb_cnt = 0;
  logic stb_prev = 1'b0;
  logic [7:0] loc_coll = 8'h00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h",
               name, act, exp);
    end
  endtask

  // Write scoreboard plus snapshot of loc_data one clock
  // after each strobe (the same-cycle collision point).
  always @(negedge clk) begin
    if (stb_prev) loc_coll = loc_data;
    stb_prev = wr_stb;
    if (wr_stb === 1'b1) begin
      wr_t e;
      stb_cnt++;
      if (exp_wq.size() == 0) begin
        chk("wr_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_wq.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e.a));
        chk("wr_data", 32'(wr_data), 32'(e.d));
      end
    end
  end

  task automatic sclk_bit(input logic b,
                          output logic rx,
                          output logic oe);
    sdio_in = b;
    #HALF;
    sclk = 1'b1;
    rx = sdio_out;
    oe = sdio_oe;
    #HALF;
    sclk = 1'b0;
  endtask

  task automatic xfer(input vec_t v);
    logic [15:0] instr;
    logic rx, oe, oe_bad, oe_ok;
    logic [7:0] rbyte, e;
    instr = {v.rw, v.w, 5'b00000, v.addr};
    @(negedge clk);
    #2;
    csb = 1'b0;
    #HALF;
    chk("busy_in", 32'(busy), 32'd1);
    oe_bad = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      sclk_bit(instr[i], rx, oe);
      if (oe) oe_bad = 1'b1;
    end
    chk("oe_instr", 32'(oe_bad), 32'd0);
    for (int b = 0; b < int'(v.nb); b++) begin
      if (!v.rw) begin
        exp_wq.push_back({v.addr - 8'(b), v.d[b]});
        for (int i = 7; i >= 0; i--) begin
          sclk_bit(v.d[b][i], rx, oe);
        end
      end else begin
        exp_rq.push_back(v.d[b]);
        rbyte = '0;
        oe_ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
          sclk_bit(1'b0, rx, oe);
          rbyte = {rbyte[6:0], rx};
          if (oe !== 1'b1) oe_ok = 1'b0;
        end
        chk("oe_data", 32'(oe_ok), 32'd1);
        if (exp_rq.size() == 0) begin
          chk("rd_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_rq.pop_front();
          chk("rd_byte", 32'(rbyte), 32'(e));
        end
      end
    end
    #HALF;
    if (v.rw) begin
      chk("oe_tail", 32'(sdio_oe),
          (v.w == 2'b11) ? 32'd1 : 32'd0);
    end
    csb = 1'b1;
    #(2 * HALF);
    chk("oe_after", 32'(sdio_oe), 32'd0);
    chk("busy_after", 32'(busy), 32'd0);
  endtask

  vec_t vecs [9];

  initial begin
    logic rx, oe;
    int stb_before;

    vecs[0] = '{rw: 1'b0, w: 2'b00, addr: 8'h14, nb: 2'd1,
                d: {8'h5A, 8'h00, 8'h00}};
    vecs[1] = '{rw: 1'b0, w: 2'b10, addr: 8'h22, nb: 2'd3,
                d: {8'h11, 8'h22, 8'h33}};
    vecs[2] = '{rw: 1'b0, w: 2'b01, addr: 8'h20, nb: 2'd2,
                d: {8'hA5, 8'h3C, 8'h00}};
    vecs[3] = '{rw: 1'b0, w: 2'b00, addr: 8'h00, nb: 2'd1,
                d: {8'hC3, 8'h00, 8'h00}};
    vecs[4] = '{rw: 1'b0, w: 2'b00, addr: 8'hFF, nb: 2'd1,
                d: {8'h7E, 8'h00, 8'h00}};
    vecs[5] = '{rw: 1'b1, w: 2'b11, addr: 8'h20, nb: 2'd2,
                d: {8'hA5, 8'h3C, 8'h00}};
    vecs[6] = '{rw: 1'b1, w: 2'b01, addr: 8'h00, nb: 2'd2,
                d: {8'hC3, 8'h7E, 8'h00}};
    vecs[7] = '{rw: 1'b1, w: 2'b10, addr: 8'h22, nb: 2'd3,
                d: {8'h11, 8'h22, 8'hA5}};
    vecs[8] = '{rw: 1'b1, w: 2'b00, addr: 8'h14, nb: 2'd1,
                d: {8'h5A, 8'h00, 8'h00}};

    rst_n = 1'b0;
    sclk = 1'b0;
    csb = 1'b1;
    sdio_in = 1'b0;
    loc_addr = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    chk("rst_sdio_out", 32'(sdio_out), 32'd0);
    chk("rst_sdio_oe", 32'(sdio_oe), 32'd0);
    chk("rst_wr_stb", 32'(wr_stb), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_loc_data", 32'(loc_data), 32'd0);

    for (int k = 0; k < 9; k++) begin
      xfer(vecs[k]);
    end

    loc_addr = 8'h14;
    repeat (2) @(negedge clk);
    chk("loc_0x14", 32'(loc_data), 32'h5A);
    loc_addr = 8'hFF;
    repeat (2) @(negedge clk);
    chk("loc_0xff", 32'(loc_data), 32'h7E);

    // Abort a write after 5 data bits.
    stb_before = stb_cnt;
    @(negedge clk);
    #2;
    csb = 1'b0;
    #HALF;
    for (int i = 15; i >= 0; i--) begin
      logic [15:0] ins;
      ins = 16'h0030;
      sclk_bit(ins[i], rx, oe);
    end
    for (int i = 0; i < 5; i++) sclk_bit(1'b1, rx, oe);
    #HALF;
    csb = 1'b1;
    #(2 * HALF);
    chk("abort_no_stb", 32'(stb_cnt - stb_before), 32'd0);
    chk("abort_ferr", 32'(frame_err), 32'd1);
    chk("abort_idle", 32'(busy), 32'd0);

    // Clean write after the abort, with a loc read collision.
    loc_addr = 8'h30;
    loc_coll = 8'hEE;
    xfer('{rw: 1'b0, w: 2'b00, addr: 8'h30, nb: 2'd1,
           d: {8'h99, 8'h00, 8'h00}});
    chk("coll_old", 32'(loc_coll), 32'h00);
    chk("loc_0x30", 32'(loc_data), 32'h99);
    chk("ferr_sticky", 32'(frame_err), 32'd1);

    // Reset in the middle of a streaming read.
    @(negedge clk);
    #2;
    csb = 1'b0;
    #HALF;
    for (int i = 15; i >= 0; i--) begin
      logic [15:0] ins;
      ins = 16'hE014;
      sclk_bit(ins[i], rx, oe);
    end
    for (int i = 0; i < 3; i++) sclk_bit(1'b0, rx, oe);
    #HALF;
    chk("mid_read_oe", 32'(sdio_oe), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rrst_oe", 32'(sdio_oe), 32'd0);
    chk("rrst_sdo", 32'(sdio_out), 32'd0);
    chk("rrst_ferr", 32'(frame_err), 32'd0);
    chk("rrst_busy", 32'(busy), 32'd0);
    chk("rrst_stb", 32'(wr_stb), 32'd0);
    chk("rrst_waddr", 32'(wr_addr), 32'd0);
    chk("rrst_wdata", 32'(wr_data), 32'd0);
    chk("rrst_loc", 32'(loc_data), 32'd0);
    rst_n = 1'b1;
    loc_addr = 8'h14;
    repeat (2) @(negedge clk);
    chk("rf_cleared", 32'(loc_data), 32'd0);
    csb = 1'b1;
    #(2 * HALF);
    chk("post_rst_ferr", 32'(frame_err), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);

    chk("wq_empty", 32'(exp_wq.size()), 32'd0);
    chk("rq_empty", 32'(exp_rq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
